// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared FSM state type, default constants and counter sizing for key_debounce
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEBOUNCE_CNT_DEF = 1000000;
  localparam int LONG_CNT_DEF     = 50000000;

  // Bits needed to hold 0..max_val inclusive; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-FF synchroniser, debounce FSM, long-press counter under KEY_LONGPRESS_EN
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int LONG_CNT     = LONG_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press_strobe,
  output logic release_strobe,
  output logic long_strobe
);

  localparam int            CW      = cnt_width(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
    $error("key_debounce_ch: DEBOUNCE_CNT must be >= 1");
  end
  if (LONG_CNT < 1) begin : g_bad_long
    $error("key_debounce_ch: LONG_CNT must be >= 1");
  end

  logic [1:0]    sync;
  logic          key_s;
  key_state_t    state;
  logic [CW-1:0] cnt;

  // Flops reset to 1 so a key held through reset still has to re-qualify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key};
  end
  assign key_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RELEASED;
      cnt            <= '0;
      level          <= 1'b0;
      press_strobe   <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      press_strobe   <= 1'b0;
      release_strobe <= 1'b0;
      case (state)
        RELEASED: begin
          if (!key_s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state        <= PRESSED;
            cnt          <= '0;
            level        <= 1'b1;
            press_strobe <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state          <= RELEASED;
            cnt            <= '0;
            level          <= 1'b0;
            release_strobe <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int            LW       = cnt_width(LONG_CNT);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT);

  logic [LW-1:0] hold;

  // Saturating at LONG_MAX gives exactly one strobe per press; a release glitch only freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      long_strobe <= 1'b0;
    end else begin
      long_strobe <= 1'b0;
      if (state == RELEASED) begin
        hold <= '0;
      end else if (state == PRESSED && hold != LONG_MAX) begin
        hold        <= hold + LW'(1);
        long_strobe <= ((hold + LW'(1)) == LONG_MAX);
      end
    end
  end
`else
  assign long_strobe = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounced press/release/level per active-low key pin; long-press strobe under KEY_LONGPRESS_EN
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS     = 2,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int LONG_CNT     = LONG_CNT_DEF
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_CNT    (LONG_CNT)
    ) u_ch (
      .clk           (CLOCK_50),
      .rst_n         (rst_n),
      .key           (KEY[i]),
      .level         (key_level[i]),
      .press_strobe  (key_press[i]),
      .release_strobe(key_release[i]),
      .long_strobe   (key_long[i])
    );
  end

endmodule
